data_mem: RTL

Parametrised, byte-addressable data memory for the single-cycle/multi-cycle CPU datapath. It replaces the fixed word RAM with:
- full MIPS-style load/store sizing (LB/LBU/LH/LHU/LW, SB/SH/SW) decoded from `order[31:26]`;
- sign/zero extension on loads;
- alignment and range fault detection;
- a configurable registered read pipeline;
- a reset-time clear sweep.

It sits between the execute stage and the writeback mux.

---
 rtl/data_mem.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem.sv
// Byte-addressable data memory with sized/extended loads, fault detection,
// a READ_LAT-deep registered load pipeline and a reset-time clear sweep.
module data_mem #(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned READ_LAT       = 1,
  parameter bit          PROTECT_ZERO   = 1'b1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [31:0]       order,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [31:0]       data_out,
  output logic              fault
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned LAST  = READ_LAT - 1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_cnt;
  logic [AW-1:0]    w_cnt_nxt;
  logic             r_ready;
  logic             r_busy;
  logic             r_fault;
  logic [31:0]      r_mem [DEPTH];
  logic [READ_LAT-1:0] r_vld;
  logic [31:0]      r_dat [READ_LAT];

  logic [5:0]       w_op;
  logic             w_is_load;
  logic             w_is_store;
  logic             w_uns;
  logic [1:0]       w_size;
  logic [IDX_W-1:0] w_idx;
  logic [AW-1:0]    w_widx;
  logic             w_bad;
  logic             w_acc;
  logic             w_load;
  logic             w_we;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rword;
  logic [7:0]       w_lane_b;
  logic [15:0]      w_lane_h;
  logic [31:0]      w_ext;
  logic [READ_LAT-1:0] w_stg_v;
  logic [31:0]      w_stg_d [READ_LAT];
  logic             w_unused;

  assign w_op     = order[31:26];
  assign w_idx    = addr[ADDR_W-1:2];
  assign w_widx   = w_idx[AW-1:0];
  assign w_unused = &{1'b0, order[25:0]};

  // Opcode decode into direction, access size and extension mode.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_uns      = 1'b0;
    w_size     = SZ_W;
    case (w_op)
      6'b100000: begin w_is_load  = 1'b1; w_size = SZ_B; end
      6'b100001: begin w_is_load  = 1'b1; w_size = SZ_H; end
      6'b100011: begin w_is_load  = 1'b1; w_size = SZ_W; end
      6'b100100: begin w_is_load  = 1'b1; w_size = SZ_B; w_uns = 1'b1; end
      6'b100101: begin w_is_load  = 1'b1; w_size = SZ_H; w_uns = 1'b1; end
      6'b101000: begin w_is_store = 1'b1; w_size = SZ_B; end
      6'b101001: begin w_is_store = 1'b1; w_size = SZ_H; end
      6'b101011: begin w_is_store = 1'b1; w_size = SZ_W; end
      default:   ;
    endcase
  end

  assign w_bad = !(w_is_load || w_is_store)
              || (64'(w_idx) >= 64'(DEPTH))
              || ((w_size == SZ_H) && addr[0])
              || ((w_size == SZ_W) && (addr[1:0] != 2'b00));

  assign w_acc  = req && r_ready;
  assign w_load = w_acc && w_is_load && !w_bad;
  assign w_we   = w_acc && w_is_store && !w_bad
               && !(PROTECT_ZERO && (w_idx == '0));

  // Store lane enables and lane-replicated write data.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = data_in;
    case (w_size)
      SZ_B: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{data_in[7:0]}};
      end
      SZ_H: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{data_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension ahead of the pipeline.
  assign w_rword  = r_mem[w_widx];
  assign w_lane_b = 8'(w_rword >> {addr[1:0], 3'b000});
  assign w_lane_h = addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_ext = w_rword;
    case (w_size)
      SZ_B: w_ext = w_uns ? {24'h0, w_lane_b} : {{24{w_lane_b[7]}}, w_lane_b};
      SZ_H: w_ext = w_uns ? {16'h0, w_lane_h} : {{16{w_lane_h[15]}}, w_lane_h};
      default: ;
    endcase
  end

  // Clear sweep walks every word once, then parks in IDLE.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == AW'(DEPTH - 1)) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      r_cnt   <= '0;
      r_ready <= !CLEAR_ON_RESET;
      r_busy  <= CLEAR_ON_RESET;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_next == S_IDLE);
      r_busy  <= (w_next == S_CLEAR);
    end
  end

  // Single write port shared by the clear sweep and stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else if (w_we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_stg_v = '0;
    for (int unsigned i = 0; i < READ_LAT; i++) w_stg_d[i] = '0;
    w_stg_v[0] = w_load;
    w_stg_d[0] = w_ext;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      w_stg_v[i] = r_vld[i-1];
      w_stg_d[i] = r_dat[i-1];
    end
  end

  // The final stage only loads on a valid so data_out holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_fault <= 1'b0;
      for (int unsigned i = 0; i < READ_LAT; i++) r_dat[i] <= '0;
    end else begin
      r_vld   <= w_stg_v;
      r_fault <= w_acc && w_bad;
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        if ((i != LAST) || w_stg_v[i]) r_dat[i] <= w_stg_d[i];
      end
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign rvalid   = r_vld[LAST];
  assign data_out = r_dat[LAST];
  assign fault    = r_fault;

endmodule
